// File: rtl/stopwatch_unit.sv
// Stopwatch timekeeping core: prescales clk to a count tick and advances a
// saturating mins:secs:hundredths chain with run/pause, lap freeze and clear.
module stopwatch_unit #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop_btn,
  input  logic       lap_btn,
  input  logic       clear_btn,
  output logic [6:0] stopwatch_unit_mins,
  output logic [5:0] stopwatch_unit_secs,
  output logic [6:0] stopwatch_unit_decs,
  output logic       running,
  output logic       max_reached
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, LAP} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [6:0]    mins_reg, mins_next, lap_mins_reg, lap_mins_next;
  logic [5:0]    secs_reg, secs_next, lap_secs_reg, lap_secs_next;
  logic [6:0]    decs_reg, decs_next, lap_decs_reg, lap_decs_next;
  logic          max_reg, max_next;
  logic [2:0]    btn_vec, btn_d_reg, btn_ev;
  logic          ev_ss, ev_lap, ev_clear;
  logic          tick, sat, at_max;

  // Bit order: 0 = start/stop, 1 = lap, 2 = clear.
  assign btn_vec = {clear_btn, lap_btn, start_stop_btn};

  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    assign btn_ev[gi] = btn_vec[gi] & ~btn_d_reg[gi];
  end

  assign ev_ss    = btn_ev[0];
  assign ev_lap   = btn_ev[1];
  assign ev_clear = btn_ev[2];
  assign at_max   = (mins_reg == 7'd99) && (secs_reg == 6'd59) && (decs_reg == 7'd99);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      presc_reg    <= '0;
      mins_reg     <= '0;
      secs_reg     <= '0;
      decs_reg     <= '0;
      lap_mins_reg <= '0;
      lap_secs_reg <= '0;
      lap_decs_reg <= '0;
      max_reg      <= 1'b0;
      btn_d_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      mins_reg     <= mins_next;
      secs_reg     <= secs_next;
      decs_reg     <= decs_next;
      lap_mins_reg <= lap_mins_next;
      lap_secs_reg <= lap_secs_next;
      lap_decs_reg <= lap_decs_next;
      max_reg      <= max_next;
      btn_d_reg    <= btn_vec;
    end
  end

  always_comb begin
    state_next    = state_reg;
    presc_next    = presc_reg;
    mins_next     = mins_reg;
    secs_next     = secs_reg;
    decs_next     = decs_reg;
    lap_mins_next = lap_mins_reg;
    lap_secs_next = lap_secs_reg;
    lap_decs_next = lap_decs_reg;
    max_next      = max_reg;
    tick          = 1'b0;

    if (state_reg == RUNNING || state_reg == LAP) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        tick       = 1'b1;
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end else if (state_reg == IDLE) begin
      presc_next = '0;
    end

    // A tick at the top of the range freezes the count instead of wrapping.
    sat = tick && at_max;
    if (sat) begin
      max_next = 1'b1;
    end else if (tick) begin
      if (decs_reg == 7'd99) begin
        decs_next = '0;
        if (secs_reg == 6'd59) begin
          secs_next = '0;
          mins_next = mins_reg + 7'd1;
        end else begin
          secs_next = secs_reg + 6'd1;
        end
      end else begin
        decs_next = decs_reg + 7'd1;
      end
    end

    if (ev_clear) begin
      state_next    = IDLE;
      presc_next    = '0;
      mins_next     = '0;
      secs_next     = '0;
      decs_next     = '0;
      lap_mins_next = '0;
      lap_secs_next = '0;
      lap_decs_next = '0;
      max_next      = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ev_ss) state_next = RUNNING;
        end
        RUNNING: begin
          if (sat || ev_ss) begin
            state_next = PAUSED;
          end else if (ev_lap) begin
            // Freeze what this edge displays, including this edge's tick.
            state_next    = LAP;
            lap_mins_next = mins_next;
            lap_secs_next = secs_next;
            lap_decs_next = decs_next;
          end
        end
        LAP: begin
          if (sat || ev_ss) state_next = PAUSED;
          else if (ev_lap)  state_next = RUNNING;
        end
        PAUSED: begin
          if (ev_ss && !max_reg) state_next = RUNNING;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign stopwatch_unit_mins = (state_reg == LAP) ? lap_mins_reg : mins_reg;
  assign stopwatch_unit_secs = (state_reg == LAP) ? lap_secs_reg : secs_reg;
  assign stopwatch_unit_decs = (state_reg == LAP) ? lap_decs_reg : decs_reg;
  assign running             = (state_reg == RUNNING) || (state_reg == LAP);
  assign max_reached         = max_reg;

endmodule
